// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor handling DIGITS decimal digits, least significant first.
// Subtraction uses ten's complement; a negative result gets a recomplement pass so F is sign-magnitude.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  m_i,
  input  logic                  cin_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  output logic [4*DIGITS-1:0]   f_o,
  output logic                  cout_o,
  output logic                  neg_o,
  output logic                  err_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, RECOMP, FIN} state_e;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] a_q, a_d;
  logic [4*DIGITS-1:0] b_q, b_d;
  logic [4*DIGITS-1:0] f_q, f_d;
  logic                m_q, m_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                neg_q, neg_d;
  logic                err_q, err_d;
  logic [IDXW-1:0]     idx_q, idx_d;

  logic                badDigit;
  logic                lastDigit;
  logic [3:0]          aDigit;
  logic [3:0]          bDigit;
  logic [3:0]          fDigit;
  logic [4:0]          sumAdd;
  logic [4:0]          sumRec;

  // One decimal digit step: binary add, then +6 correction when the sum exceeds 9.
  function automatic logic [4:0] bcdDigit(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] z;
    z = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    if (z > 5'd9) bcdDigit = {1'b1, z[3:0] + 4'd6};
    else          bcdDigit = z;
  endfunction

  always_comb begin
    badDigit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a_i[i*4 +: 4] > 4'd9) || (b_i[i*4 +: 4] > 4'd9)) badDigit = 1'b1;
    end
  end

  assign lastDigit = (idx_q == IDXW'(DIGITS - 1));
  assign aDigit    = a_q[idx_q*4 +: 4];
  assign bDigit    = m_q ? (4'd9 - b_q[idx_q*4 +: 4]) : b_q[idx_q*4 +: 4];
  assign fDigit    = f_q[idx_q*4 +: 4];
  assign sumAdd    = bcdDigit(aDigit, bDigit, carry_q);
  assign sumRec    = bcdDigit(4'd9 - fDigit, 4'd0, carry_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    m_d     = m_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    neg_d   = neg_q;
    err_d   = err_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start_i) begin
          a_d    = a_i;
          b_d    = b_i;
          m_d    = m_i;
          f_d    = '0;
          cout_d = 1'b0;
          neg_d  = 1'b0;
          idx_d  = '0;
          if (badDigit) begin
            err_d   = 1'b1;
            carry_d = 1'b0;
            state_d = FIN;
          end else begin
            err_d   = 1'b0;
            carry_d = m_i ? ~cin_i : cin_i;
            state_d = ADD;
          end
        end
      end
      ADD: begin
        f_d[idx_q*4 +: 4] = sumAdd[3:0];
        carry_d = sumAdd[4];
        if (lastDigit) begin
          idx_d = '0;
          if (!m_q || sumAdd[4]) begin
            cout_d  = sumAdd[4];
            state_d = FIN;
          end else begin
            // No final carry on subtract means A-B-CIN < 0: recomplement to get the magnitude.
            cout_d  = 1'b0;
            neg_d   = 1'b1;
            carry_d = 1'b1;
            state_d = RECOMP;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RECOMP: begin
        f_d[idx_q*4 +: 4] = sumRec[3:0];
        carry_d = sumRec[4];
        if (lastDigit) begin
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
    end
  end

  assign f_o    = f_q;
  assign cout_o = cout_q;
  assign neg_o  = neg_q;
  assign err_o  = err_q;
  assign busy_o = (state_q == ADD) || (state_q == RECOMP);
  assign done_o = (state_q == FIN);

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Directed bench for bcd_addsub_serial with DIGITS=4: results, latency, error path, handshake and reset.
module tb_bcd_addsub_serial;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic        mode;
  logic        cinIn;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic [15:0] f;
  logic        cout;
  logic        neg;
  logic        err;
  logic        busy;
  logic        done;

  int compared   = 0;
  int mismatched = 0;

  bcd_addsub_serial #(.DIGITS(4)) dut (
    .clk_i  (clk),
    .rst_ni (rstN),
    .start_i(start),
    .m_i    (mode),
    .cin_i  (cinIn),
    .a_i    (aIn),
    .b_i    (bIn),
    .f_o    (f),
    .cout_o (cout),
    .neg_o  (neg),
    .err_o  (err),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  // Start one operation at the next rising edge and count edges until DONE shows (bounded).
  task automatic applyStimulus(input logic m, input logic c, input logic [15:0] a,
                               input logic [15:0] b, output int cycles);
    @(negedge clk);
    mode = m; cinIn = c; aIn = a; bIn = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; mode = 1'b0; cinIn = 1'b0; aIn = '0; bIn = '0;
    repeat (2) @(negedge clk);
    compared++;
    if ({f, cout, neg, err, busy, done} !== 21'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", {f, cout, neg, err, busy, done}, 21'h0);
    end
    rstN = 1'b1;
  endtask

  task automatic test_add();
    int cycles;
    @(negedge clk);
    mode = 1'b0; cinIn = 1'b0; aIn = 16'h1234; bIn = 16'h5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      compared++;
      if ({busy, done} !== 2'b10) begin
        mismatched++;
        $display("[TB] FAIL add_busy_edge%0d: got %b expected %b", k, {busy, done}, 2'b10);
      end
      @(posedge clk); #1;
    end
    compared++;
    if ({busy, done, f, cout, neg, err} !== {2'b01, 16'h6912, 3'b000}) begin
      mismatched++;
      $display("[TB] FAIL add_1234_5678: got %h expected %h", {busy, done, f, cout, neg, err},
               {2'b01, 16'h6912, 3'b000});
    end
    @(posedge clk); #1;
    compared++;
    if ({done, f} !== {1'b0, 16'h6912}) begin
      mismatched++;
      $display("[TB] FAIL add_done_pulse_hold: got %h expected %h", {done, f}, {1'b0, 16'h6912});
    end
    applyStimulus(1'b0, 1'b0, 16'h9999, 16'h0001, cycles);
    compared++;
    if ({f, cout, neg, cycles} !== {16'h0000, 2'b10, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL add_overflow: got f=%h cout=%b neg=%b cyc=%0d expected f=0000 cout=1 neg=0 cyc=4",
               f, cout, neg, cycles);
    end
    applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, cycles);
    compared++;
    if ({f, cout, neg} !== {16'h0001, 2'b00}) begin
      mismatched++;
      $display("[TB] FAIL add_carry_in: got f=%h cout=%b neg=%b expected f=0001 cout=0 neg=0", f, cout, neg);
    end
  endtask

  task automatic test_subtract();
    int cycles;
    applyStimulus(1'b1, 1'b0, 16'h5000, 16'h1234, cycles);
    compared++;
    if ({f, cout, neg, err, cycles} !== {16'h3766, 3'b100, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL sub_5000_1234: got f=%h cout=%b neg=%b err=%b cyc=%0d expected f=3766 cout=1 neg=0 err=0 cyc=4",
               f, cout, neg, err, cycles);
    end
    applyStimulus(1'b1, 1'b0, 16'h0777, 16'h0777, cycles);
    compared++;
    if ({f, cout, neg} !== {16'h0000, 2'b10}) begin
      mismatched++;
      $display("[TB] FAIL sub_equal_zero: got f=%h cout=%b neg=%b expected f=0000 cout=1 neg=0", f, cout, neg);
    end
  endtask

  task automatic test_negative();
    int cycles;
    applyStimulus(1'b1, 1'b0, 16'h0012, 16'h0345, cycles);
    compared++;
    if ({f, cout, neg, cycles} !== {16'h0333, 2'b01, 32'd8}) begin
      mismatched++;
      $display("[TB] FAIL sub_negative: got f=%h cout=%b neg=%b cyc=%0d expected f=0333 cout=0 neg=1 cyc=8",
               f, cout, neg, cycles);
    end
    applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000, cycles);
    compared++;
    if ({f, cout, neg, cycles} !== {16'h0001, 2'b01, 32'd8}) begin
      mismatched++;
      $display("[TB] FAIL sub_borrow_neg: got f=%h cout=%b neg=%b cyc=%0d expected f=0001 cout=0 neg=1 cyc=8",
               f, cout, neg, cycles);
    end
  endtask

  task automatic test_error();
    int cycles;
    applyStimulus(1'b0, 1'b0, 16'h00A1, 16'h0000, cycles);
    compared++;
    if ({f, cout, neg, err, cycles} !== {16'h0000, 3'b001, 32'd0}) begin
      mismatched++;
      $display("[TB] FAIL err_digit: got f=%h cout=%b neg=%b err=%b cyc=%0d expected f=0000 cout=0 neg=0 err=1 cyc=0",
               f, cout, neg, err, cycles);
    end
    applyStimulus(1'b0, 1'b0, 16'h0001, 16'h0002, cycles);
    compared++;
    if ({f, cout, err, cycles} !== {16'h0003, 2'b00, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL err_cleared: got f=%h cout=%b err=%b cyc=%0d expected f=0003 cout=0 err=0 cyc=4",
               f, cout, err, cycles);
    end
  endtask

  task automatic test_busy_ignore();
    int cycles;
    @(negedge clk);
    mode = 1'b0; cinIn = 1'b0; aIn = 16'h1111; bIn = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    mode = 1'b1; aIn = 16'h9999; bIn = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 2;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    compared++;
    if ({f, cout, neg, cycles} !== {16'h3333, 2'b00, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL busy_ignore: got f=%h cout=%b neg=%b cyc=%0d expected f=3333 cout=0 neg=0 cyc=4",
               f, cout, neg, cycles);
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    applyStimulus(1'b0, 1'b0, 16'h0001, 16'h0001, cycles);
    compared++;
    if ({done, f} !== {1'b1, 16'h0002}) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got %h expected %h", {done, f}, {1'b1, 16'h0002});
    end
    mode = 1'b1; cinIn = 1'b0; aIn = 16'h0100; bIn = 16'h0001; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    compared++;
    if ({busy, done} !== 2'b10) begin
      mismatched++;
      $display("[TB] FAIL b2b_accept: got %b expected %b", {busy, done}, 2'b10);
    end
    cycles = 0;
    while (!done && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    compared++;
    if ({f, cout, neg, cycles} !== {16'h0099, 2'b10, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got f=%h cout=%b neg=%b cyc=%0d expected f=0099 cout=1 neg=0 cyc=4",
               f, cout, neg, cycles);
    end
  endtask

  task automatic test_reset_midop();
    int cycles;
    int doneSeen;
    @(negedge clk);
    mode = 1'b0; cinIn = 1'b0; aIn = 16'h4444; bIn = 16'h4444; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    compared++;
    if ({f, cout, neg, err, busy, done} !== 21'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_midop: got %h expected %h", {f, cout, neg, err, busy, done}, 21'h0);
    end
    doneSeen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) doneSeen++;
    end
    @(negedge clk);
    rstN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done || busy) doneSeen++;
    end
    compared++;
    if (doneSeen !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_no_done: got %0d active cycles expected 0", doneSeen);
    end
    applyStimulus(1'b0, 1'b0, 16'h0005, 16'h0005, cycles);
    compared++;
    if ({f, cout, neg, cycles} !== {16'h0010, 2'b00, 32'd4}) begin
      mismatched++;
      $display("[TB] FAIL after_reset: got f=%h cout=%b neg=%b cyc=%0d expected f=0010 cout=0 neg=0 cyc=4",
               f, cout, neg, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_negative();
    test_error();
    test_busy_ignore();
    test_back_to_back();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
